// File: rtl/acc_pkg.sv
// ----------------------------------------------------------------------------
// acc_pkg
// Shared types and constants for the matrix-multiply engine.
//   DIM        : matrix dimension (must be a power of two, indices are packed
//                by concatenation)
//   acc_word_t : one 32-bit signed element, packed as [3:0][7:0]
//   acc_mat_t  : a full DIM x DIM matrix, row-major
//   acc_state_e: engine FSM states
// ----------------------------------------------------------------------------
package acc_pkg;

  localparam int DIM   = 16;
  localparam int N     = DIM * DIM;
  localparam int IDX_W = $clog2(DIM);
  // A DIM-term sum of 64-bit products needs log2(DIM) extra bits of headroom.
  localparam int ACC_W = 64 + IDX_W;

  typedef logic [3:0][7:0] acc_word_t;
  typedef acc_word_t acc_mat_t [DIM*DIM-1:0];

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } acc_state_e;

endpackage

// File: rtl/acc_mac_unit.sv
// ----------------------------------------------------------------------------
// acc_mac_unit
// Signed 32x32 multiply with a wide accumulator. result_o is the final() view
// of (acc + product), valid in the cycle last_i is high.
// Build option: ACC_MATMUL_SATURATE_EN selects clamping to signed 32-bit;
// without it the result wraps (low 32 bits).
// Ports:
//   clk, rst_i  : clock, async active-high reset
//   en_i        : accumulate this cycle
//   clear_i     : zero the accumulator (start of run)
//   last_i      : final term of a dot product; accumulator clears afterwards
//   a_i, b_i    : operands
//   result_o    : final(acc + a*b)
// ----------------------------------------------------------------------------
module acc_mac_unit
  import acc_pkg::*;
(
  input  logic      clk,
  input  logic      rst_i,
  input  logic      en_i,
  input  logic      clear_i,
  input  logic      last_i,
  input  acc_word_t a_i,
  input  acc_word_t b_i,
  output acc_word_t result_o
);

  logic [63:0]      prod;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] acc_q, acc_d;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign prod = {{32{a_i[3][7]}}, a_i} * {{32{b_i[3][7]}}, b_i};
  assign sum  = acc_q + {{IDX_W{prod[63]}}, prod};

`ifdef ACC_MATMUL_SATURATE_EN
  // In range iff every bit from 31 upward equals the sign bit.
  always_comb begin
    if ((sum[ACC_W-1:31] == '0) || (sum[ACC_W-1:31] == '1)) begin
      result_o = sum[31:0];
    end else if (sum[ACC_W-1]) begin
      result_o = 32'h8000_0000;
    end else begin
      result_o = 32'h7FFF_FFFF;
    end
  end
`else
  assign result_o = sum[31:0];
`endif

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = last_i ? '0 : sum;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/acc_matmul_engine.sv
// ----------------------------------------------------------------------------
// acc_matmul_engine
// Computes C = A x B one multiply-accumulate per cycle, row-major order.
// Build option: ACC_MATMUL_SATURATE_EN (see acc_mac_unit) clamps results
// instead of wrapping; timing is identical either way.
// Ports:
//   clk      : clock
//   rst_i    : async active-high reset
//   start_i  : start level; a rising edge starts a run when idle
//   acc_in_A : matrix A, element i*DIM+k (read live during the run)
//   acc_in_B : matrix B, element k*DIM+j (read live during the run)
//   acc_out  : matrix C, element i*DIM+j, each written when it completes
//   busy_o   : high for the DIM^3 compute cycles
//   done_o   : one-cycle pulse after the last element is written
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for a start rising edge
// COMPUTE | one MAC per cycle, walking k fastest, then j, i
// DONE    | single-cycle completion pulse
// ----------------------------------------------------------------------------
module acc_matmul_engine
  import acc_pkg::*;
(
  input  logic     clk,
  input  logic     rst_i,
  input  logic     start_i,
  input  acc_mat_t acc_in_A,
  input  acc_mat_t acc_in_B,
  output acc_mat_t acc_out,
  output logic     busy_o,
  output logic     done_o
);

  acc_state_e       state_q, state_d;
  logic             start_q;
  logic             trigger;
  logic             clear;
  logic [IDX_W-1:0] i_q, j_q, k_q;
  logic             i_last, j_last, k_last;
  acc_mat_t         acc_out_q;
  acc_word_t        mac_result;

  assign trigger = start_i & ~start_q;
  assign i_last  = (i_q == IDX_W'(DIM-1));
  assign j_last  = (j_q == IDX_W'(DIM-1));
  assign k_last  = (k_q == IDX_W'(DIM-1));

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = COMPUTE;
          clear   = 1'b1;
        end
      end
      COMPUTE: begin
        busy_o = 1'b1;
        if (i_last && j_last && k_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_i;
      if (clear) begin
        i_q <= '0;
        j_q <= '0;
        k_q <= '0;
      end else if (state_q == COMPUTE) begin
        k_q <= k_last ? '0 : k_q + 1'b1;
        if (k_last) begin
          j_q <= j_last ? '0 : j_q + 1'b1;
          if (j_last) begin
            i_q <= i_last ? '0 : i_q + 1'b1;
          end
        end
      end
    end
  end

  // DIM is a power of two, so row-major indices are plain concatenations.
  acc_mac_unit u_mac (
    .clk      (clk),
    .rst_i    (rst_i),
    .en_i     (state_q == COMPUTE),
    .clear_i  (clear),
    .last_i   (k_last),
    .a_i      (acc_in_A[{i_q, k_q}]),
    .b_i      (acc_in_B[{k_q, j_q}]),
    .result_o (mac_result)
  );

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      for (int e = 0; e < N; e++) begin
        acc_out_q[e] <= '0;
      end
    end else if ((state_q == COMPUTE) && k_last) begin
      acc_out_q[{i_q, j_q}] <= mac_result;
    end
  end

  assign acc_out = acc_out_q;

endmodule

// File: tb/tb_acc_matmul_engine.sv
module tb_acc_matmul_engine;
  import acc_pkg::*;

  logic     clk = 1'b0;
  logic     rst_i;
  logic     start_i;
  acc_mat_t a_m, b_m, c_m;
  logic     busy_o, done_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  acc_matmul_engine dut (
    .clk      (clk),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .acc_in_A (a_m),
    .acc_in_B (b_m),
    .acc_out  (c_m),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // A = identity
  task automatic set_a_identity();
    for (int e = 0; e < N; e++) a_m[e] = ((e / DIM) == (e % DIM)) ? 32'd1 : 32'd0;
  endtask

  task automatic set_a_const(input logic [31:0] v);
    for (int e = 0; e < N; e++) a_m[e] = v;
  endtask

  task automatic set_b_const(input logic [31:0] v);
    for (int e = 0; e < N; e++) b_m[e] = v;
  endtask

  task automatic set_b_index();
    for (int e = 0; e < N; e++) b_m[e] = 32'(e);
  endtask

  task automatic check_c_const(input string tag, input logic [31:0] v);
    for (int e = 0; e < N; e++) check_val(tag, 64'(c_m[e]), 64'(v));
  endtask

  task automatic check_c_index(input string tag);
    for (int e = 0; e < N; e++) check_val(tag, 64'(c_m[e]), 64'(e));
  endtask

  // Called at a negedge with start_i low and start_q low. Raises start_i and
  // watches a fixed window; busy must last 4096 cycles, done lands at 4097.
  task automatic run_timed(input string tag, input bit toggle);
    int busy_cnt = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    start_i = 1'b1;
    for (int c = 1; c <= 4200; c++) begin
      @(negedge clk);
      if (busy_o) busy_cnt++;
      if (done_o) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (toggle && c >= 10 && c <= 40) start_i = c[0];
    end
    start_i = 1'b0;
    check_val({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd4096);
    check_val({tag, "_done_cycle"}, 64'(done_cyc), 64'd4097);
    check_val({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    int done_cnt;
    int busy_cnt;
    logic [31:0] sat_exp;

    rst_i   = 1'b1;
    start_i = 1'b0;
    set_a_const(32'd0);
    set_b_const(32'd0);
    #1;
    check_val("rst_busy", 64'(busy_o), 64'd0);
    check_val("rst_done", 64'(done_o), 64'd0);
    check_c_const("rst_c", 32'd0);
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check_val("idle_busy", 64'(busy_o), 64'd0);

    // 1: identity x index matrix
    set_a_identity();
    set_b_index();
    run_timed("t1", 1'b0);
    check_c_index("t1_c");

    // 2: -1 x 2 summed 16 times
    set_a_const(32'hFFFF_FFFF);
    set_b_const(32'd2);
    run_timed("t2", 1'b0);
    check_c_const("t2_c", 32'hFFFF_FFE0);

    // 3: max positive squared, 16 terms
`ifdef ACC_MATMUL_SATURATE_EN
    sat_exp = 32'h7FFF_FFFF;
`else
    sat_exp = 32'h0000_0010;
`endif
    set_a_const(32'h7FFF_FFFF);
    set_b_const(32'h7FFF_FFFF);
    run_timed("t3", 1'b0);
    check_c_const("t3_c", sat_exp);

    // 4a: level held high gives one run
    done_cnt = 0;
    busy_cnt = 0;
    start_i = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (done_o) done_cnt++;
      if (busy_o) busy_cnt++;
    end
    start_i = 1'b0;
    @(negedge clk);
    check_val("t4_held_done_pulses", 64'(done_cnt), 64'd1);
    check_val("t4_held_busy_cycles", 64'(busy_cnt), 64'd4096);

    // 4b: toggling start during busy changes nothing
    run_timed("t4_toggle", 1'b1);

    // 5: reset mid-run (acc_out currently holds t3 results)
    start_i = 1'b1;
    repeat (2000) @(negedge clk);
    check_val("t5_busy_before_rst", 64'(busy_o), 64'd1);
    rst_i = 1'b1;
    #1;
    check_val("t5_busy_in_rst", 64'(busy_o), 64'd0);
    check_val("t5_done_in_rst", 64'(done_o), 64'd0);
    check_c_const("t5_c_rst", 32'd0);
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    done_cnt = 0;
    busy_cnt = 0;
    for (int c = 0; c < 2200; c++) begin
      @(negedge clk);
      if (done_o) done_cnt++;
      if (busy_o) busy_cnt++;
    end
    check_val("t5_no_done_after_rst", 64'(done_cnt), 64'd0);
    check_val("t5_no_busy_after_rst", 64'(busy_cnt), 64'd0);
    set_a_identity();
    set_b_index();
    run_timed("t5_rerun", 1'b0);
    check_c_index("t5_c");

    // 6: results persist; during run 2 only element 0 updates after 16 cycles
    set_a_identity();
    set_b_const(32'd1);
    run_timed("t6_run1", 1'b0);
    check_c_const("t6_run1_c", 32'd1);
    set_b_const(32'd2);
    start_i = 1'b1;
    repeat (16) @(negedge clk);
    check_val("t6_c0_before_write", 64'(c_m[0]), 64'd1);
    @(negedge clk);
    check_val("t6_c0_after_16", 64'(c_m[0]), 64'd2);
    for (int e = 1; e < N; e++) check_val("t6_c_others_hold", 64'(c_m[e]), 64'd1);
    done_cnt = 0;
    for (int c = 0; c < 4200; c++) begin
      @(negedge clk);
      if (done_o) done_cnt++;
    end
    start_i = 1'b0;
    check_val("t6_run2_done_pulses", 64'(done_cnt), 64'd1);
    check_c_const("t6_run2_c", 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
